// File: rtl/sync_fifo_rd_stream_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sync_fifo_rd_stream_pkg
// Purpose  : Shared types and constants for the FIFO read-side stream adapter:
//            occupancy encoding of the 2-entry skid buffer and its depth.
// Revision : 1.0 - initial release
// ============================================================================
package sync_fifo_rd_stream_pkg;

    // Occupancy of the head/tail buffer
    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_TWO   = 2'd2
    } occ_e;

    // Buffer entries; also the credit limit on outstanding words
    localparam int unsigned BUF_DEPTH = 2;

endpackage : sync_fifo_rd_stream_pkg
`default_nettype wire

// File: rtl/fifo_rd_skid2.sv
`default_nettype none
// ============================================================================
// Module   : fifo_rd_skid2
// Purpose  : Two-entry head/tail register pair. Words arriving on push fill
//            the buffer in order; pop removes the head. The head register and
//            the valid flag are both flops so the stream outputs are clean.
// Revision : 1.0 - initial release
// ============================================================================
module fifo_rd_skid2
    import sync_fifo_rd_stream_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output occ_e                  occ,
    output logic                  valid,
    output logic [DATA_WIDTH-1:0] head
);

    logic [DATA_WIDTH-1:0] tail;

    // Occupancy FSM with head/tail data movement; valid tracks occ != EMPTY
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ   <= OCC_EMPTY;
            valid <= 1'b0;
            head  <= '0;
            tail  <= '0;
        end else if (clear) begin
            occ   <= OCC_EMPTY;
            valid <= 1'b0;
        end else begin
            case (occ)
                OCC_EMPTY: begin
                    // A pop cannot happen here since valid is low
                    if (push) begin
                        head  <= push_data;
                        occ   <= OCC_ONE;
                        valid <= 1'b1;
                    end
                end
                OCC_ONE: begin
                    if (push && pop) begin
                        head <= push_data;
                    end else if (push) begin
                        tail <= push_data;
                        occ  <= OCC_TWO;
                    end else if (pop) begin
                        occ   <= OCC_EMPTY;
                        valid <= 1'b0;
                    end
                end
                OCC_TWO: begin
                    // Push without pop is excluded by the upstream credit check
                    if (pop) begin
                        head <= tail;
                        if (push) begin
                            tail <= push_data;
                        end else begin
                            occ <= OCC_ONE;
                        end
                    end
                end
                default: begin
                    occ   <= OCC_EMPTY;
                    valid <= 1'b0;
                end
            endcase
        end
    end

endmodule : fifo_rd_skid2
`default_nettype wire

// File: rtl/sync_fifo_rd_stream.sv
`default_nettype none
// ============================================================================
// Module   : sync_fifo_rd_stream
// Purpose  : Read-side adapter for a synchronous FIFO with a registered read
//            port. Issues reads against a 2-word credit, captures returning
//            words into a skid buffer and presents a valid/ready stream at
//            full throughput. Counts delivered words.
// Revision : 1.0 - initial release
// ============================================================================
module sync_fifo_rd_stream
    import sync_fifo_rd_stream_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    output logic                  fifo_rd_en,
    input  logic                  en,
    input  logic                  flush,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic [CNT_W-1:0]      rd_count
);

    occ_e       occ;
    logic       inflight;
    logic       pop;
    logic [2:0] level;

    assign pop = m_valid && m_ready;

    // Words that will still be held after this cycle if no new read is issued
    assign level = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};

    assign fifo_rd_en = en && !flush && !fifo_empty && (level < 3'(BUF_DEPTH));

    // Marks the cycle in which fifo_data carries a freshly read word
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight <= 1'b0;
        end else begin
            inflight <= flush ? 1'b0 : fifo_rd_en;
        end
    end

    // Delivered-word counter; a pop during flush still counts
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_count <= '0;
        end else if (pop) begin
            rd_count <= rd_count + 1'b1;
        end
    end

    fifo_rd_skid2 #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (flush),
        .push      (inflight && !flush),
        .push_data (fifo_data),
        .pop       (pop),
        .occ       (occ),
        .valid     (m_valid),
        .head      (m_data)
    );

endmodule : sync_fifo_rd_stream
`default_nettype wire

// File: tb/tb_sync_fifo_rd_stream.sv
`default_nettype none
// ============================================================================
// Module   : tb_sync_fifo_rd_stream
// Purpose  : Self-checking bench for sync_fifo_rd_stream. A depth-16 FIFO with
//            registered read port is modelled here; every word the FIFO hands
//            out is queued and each delivered stream word must match the head.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sync_fifo_rd_stream;

    localparam int DW    = 8;
    localparam int CW    = 16;
    localparam int DEPTH = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          fifo_empty;
    logic [DW-1:0] fifo_data = '0;
    logic          fifo_rd_en;
    logic          en;
    logic          flush;
    logic          m_valid;
    logic          m_ready;
    logic [DW-1:0] m_data;
    logic [CW-1:0] rd_count;

    logic          wr_en;
    logic [DW-1:0] wr_data;

    int n_assert = 0;
    int n_fail   = 0;
    int pops     = 0;

    always #5 clk = ~clk;

    sync_fifo_rd_stream #(
        .DATA_WIDTH (DW),
        .CNT_W      (CW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .fifo_empty (fifo_empty),
        .fifo_data  (fifo_data),
        .fifo_rd_en (fifo_rd_en),
        .en         (en),
        .flush      (flush),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .rd_count   (rd_count)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // FIFO model: registered read port, words read are queued as expected output
    logic [DW-1:0] mem [DEPTH];
    int            fcount = 0;
    int            wp = 0;
    int            rp = 0;
    logic [DW-1:0] exp_q [$];

    assign fifo_empty = (fcount == 0);

    always @(posedge clk) begin
        if (fifo_rd_en && fcount > 0) begin
            fifo_data <= mem[rp];
            exp_q.push_back(mem[rp]);
            rp <= (rp + 1) % DEPTH;
        end
        if (wr_en && fcount < DEPTH) begin
            mem[wp] <= wr_data;
            wp <= (wp + 1) % DEPTH;
        end
        fcount <= fcount + ((wr_en && fcount < DEPTH) ? 1 : 0)
                         - ((fifo_rd_en && fcount > 0) ? 1 : 0);
    end

    // Stream monitor on the falling edge
    always @(negedge clk) begin
        if (rst_n) begin
            if (fifo_rd_en) check("rd_en_while_empty", 32'(fifo_empty), 32'd0);
            check("outstanding_le_2", 32'(exp_q.size() <= 2), 32'd1);
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) check("unexpected_word", 32'd1, 32'd0);
                else check("order", 32'(m_data), 32'(exp_q.pop_front()));
                pops++;
            end
            if (flush) exp_q.delete();
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_burst(input logic [DW-1:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            wr_data = base + DW'(i);
            wr_en   = 1'b1;
            tick();
        end
        wr_en = 1'b0;
    endtask

    task automatic drain(input string tag);
        bit done;
        done    = 1'b0;
        en      = 1'b1;
        m_ready = 1'b1;
        for (int c = 0; c < 300 && !done; c++) begin
            if (exp_q.size() == 0 && !m_valid && fcount == 0) done = 1'b1;
            else tick();
        end
        check(tag, 32'(done), 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int p0;
        int nw;
        bit done;

        rst_n = 1'b0; en = 1'b0; flush = 1'b0; m_ready = 1'b0;
        wr_en = 1'b0; wr_data = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_m_valid", 32'(m_valid), 32'd0);
        check("rst_m_data", 32'(m_data), 32'd0);
        check("rst_rd_count", 32'(rd_count), 32'd0);
        rst_n = 1'b1;
        tick();

        // 1: 16 words back-to-back, latency 2 after first read
        m_ready = 1'b1;
        write_burst(8'h01, 16);
        en = 1'b1;
        #1;
        check("t1_first_rd_en", 32'(fifo_rd_en), 32'd1);
        tick(); #1;
        check("t1_valid_n1", 32'(m_valid), 32'd0);
        for (int i = 1; i <= 16; i++) begin
            tick(); #1;
            check("t1_valid", 32'(m_valid), 32'd1);
            check("t1_data", 32'(m_data), 32'(i));
        end
        tick(); #1;
        check("t1_valid_end", 32'(m_valid), 32'd0);
        check("t1_rd_count", 32'(rd_count), 32'd16);
        tick();

        // 2: backpressure holds head stable, only 2 words pulled
        en = 1'b0; m_ready = 1'b0;
        write_burst(8'hA0, 8);
        en = 1'b1;
        repeat (3) tick();
        for (int i = 0; i < 10; i++) begin
            tick(); #1;
            check("t2_valid", 32'(m_valid), 32'd1);
            check("t2_data", 32'(m_data), 32'hA0);
        end
        check("t2_fifo_left", 32'(fcount), 32'd6);
        check("t2_rd_count", 32'(rd_count), 32'd16);
        tick();
        drain("t2_drain");

        // 3: random traffic and random backpressure
        p0 = pops; nw = 0; done = 1'b0;
        for (int c = 0; c < 20000 && !done; c++) begin
            m_ready = 1'($urandom % 2);
            if (nw < 1000 && fcount < DEPTH && ($urandom % 4) != 0) begin
                wr_en = 1'b1; wr_data = DW'($urandom); nw++;
            end else begin
                wr_en = 1'b0;
            end
            tick();
            if (nw == 1000 && exp_q.size() == 0 && fcount == 0 && !m_valid && !wr_en)
                done = 1'b1;
        end
        wr_en = 1'b0;
        check("t3_complete", 32'(done), 32'd1);
        check("t3_delivered", 32'(pops - p0), 32'd1000);
        check("t3_rd_count", 32'(rd_count), 32'(pops % (1 << CW)));

        // 4: flush with one word buffered and one on fifo_data
        en = 1'b0; m_ready = 1'b0;
        write_burst(8'hB0, 5);
        en = 1'b1;
        tick();
        tick();
        flush = 1'b1;
        #1;
        check("t4_rd_en_in_flush", 32'(fifo_rd_en), 32'd0);
        check("t4_head_before", 32'(m_data), 32'hB0);
        tick();
        flush = 1'b0;
        #1;
        check("t4_valid_after", 32'(m_valid), 32'd0);
        m_ready = 1'b1;
        done = 1'b0;
        for (int c = 0; c < 10 && !done; c++) begin
            tick(); #1;
            if (m_valid) done = 1'b1;
        end
        check("t4_valid_again", 32'(m_valid), 32'd1);
        check("t4_next_word", 32'(m_data), 32'hB2);
        tick();
        drain("t4_drain");

        // 5: en low with one word buffered: it drains, nothing else read
        en = 1'b0; m_ready = 1'b0;
        write_burst(8'hC0, 3);
        en = 1'b1;
        tick();
        en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick(); #1;
            check("t5_rd_en", 32'(fifo_rd_en), 32'd0);
            check("t5_valid", 32'(m_valid), 32'd1);
            check("t5_data", 32'(m_data), 32'hC0);
        end
        tick();
        m_ready = 1'b1;
        #1;
        check("t5_rd_en_pop", 32'(fifo_rd_en), 32'd0);
        tick(); #1;
        check("t5_valid_end", 32'(m_valid), 32'd0);
        check("t5_fifo_left", 32'(fcount), 32'd2);
        tick();

        // 6: asynchronous reset mid-stream
        en = 1'b1; m_ready = 1'b1;
        write_burst(8'hD0, 8);
        tick();
        #2;
        rst_n = 1'b0;
        en    = 1'b0;
        exp_q.delete();
        pops = 0;
        #1;
        check("t6_valid", 32'(m_valid), 32'd0);
        check("t6_data", 32'(m_data), 32'd0);
        check("t6_rd_count", 32'(rd_count), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        drain("t6_drain");
        check("t6_count_after", 32'(rd_count), 32'(pops % (1 << CW)));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule : tb_sync_fifo_rd_stream
`default_nettype wire
